// File: rtl/rob_param.sv
// -----------------------------------------------------------------------------
// rob_param -- parameterised reorder buffer for a renaming out-of-order core.
//
// The ROB holds one entry per in-flight instruction. Each entry stores the
// logical destination, the newly allocated physical tag and the physical tag
// it replaced, plus a "done" flag set by execution completion. Entries retire
// in program order from the head. Entries are allocated at the tail.
//
// Head and tail are IDX_W+1 bit pointers. The MSB is a wrap bit, so full and
// empty can be told apart without a separate counter.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   rob_dis_vld_i             dispatch request
//   rob_dis_logic_dest_i      logical destination of the dispatching op
//   rob_dis_dest_tag_i        new physical tag (from the freelist)
//   rob_dis_old_tag_i         previous mapping (from the map table)
//   rob_dis_rdy_o             an entry is free (registered full only)
//   rob_dis_idx_o             index the current dispatch is written to
//   rob_cmpl_vld_i/_idx_i     execution-complete strobe and ROB index
//   rob_ret_vld_o             head entry is done and may retire
//   rob_ret_rdy_i             retire consumer accepts the head entry
//   rob_ret_logic_dest_o,
//   rob_ret_dest_tag_o,
//   rob_ret_old_tag_o         fields of the head entry (always presented)
//   rob_sq_vld_i/_idx_i       mispredict: drop every entry younger than idx
//   rob_flush_i               full flush; overrides every other request
//   rob_full_o, rob_empty_o   occupancy flags
//   rob_cnt_o                 occupancy, 0..ROB_DEPTH
// -----------------------------------------------------------------------------
module rob_param #(
  parameter int ROB_DEPTH = 32,
  parameter int TAG_W     = 6,
  parameter int ARF_W     = 5,
  localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             rob_dis_vld_i,
  input  logic [ARF_W-1:0] rob_dis_logic_dest_i,
  input  logic [TAG_W-1:0] rob_dis_dest_tag_i,
  input  logic [TAG_W-1:0] rob_dis_old_tag_i,
  output logic             rob_dis_rdy_o,
  output logic [IDX_W-1:0] rob_dis_idx_o,

  input  logic             rob_cmpl_vld_i,
  input  logic [IDX_W-1:0] rob_cmpl_idx_i,

  output logic             rob_ret_vld_o,
  input  logic             rob_ret_rdy_i,
  output logic [ARF_W-1:0] rob_ret_logic_dest_o,
  output logic [TAG_W-1:0] rob_ret_dest_tag_o,
  output logic [TAG_W-1:0] rob_ret_old_tag_o,

  input  logic             rob_sq_vld_i,
  input  logic [IDX_W-1:0] rob_sq_idx_i,

  input  logic             rob_flush_i,

  output logic             rob_full_o,
  output logic             rob_empty_o,
  output logic [IDX_W:0]   rob_cnt_o
);

  // Elaboration-time guard on the geometry the pointer arithmetic relies on.
  if (ROB_DEPTH < 4 || (ROB_DEPTH & (ROB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rob_param: ROB_DEPTH must be a power of two and at least 4");
  end

  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W:0]     head_ptr, tail_ptr;
  logic [IDX_W:0]     head_nxt, tail_nxt;
  logic [ROB_DEPTH-1:0] done_q, done_nxt;

  logic [ARF_W-1:0]   ent_logic_dest [ROB_DEPTH];
  logic [TAG_W-1:0]   ent_dest_tag   [ROB_DEPTH];
  logic [TAG_W-1:0]   ent_old_tag    [ROB_DEPTH];

  logic [IDX_W-1:0]   head_idx, tail_idx;
  logic               head_wrap;

  assign head_idx  = head_ptr[IDX_W-1:0];
  assign tail_idx  = tail_ptr[IDX_W-1:0];
  assign head_wrap = head_ptr[IDX_W];

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  logic [IDX_W:0] cnt;
  logic           full, empty;

  // Modulo-2^(IDX_W+1) subtraction gives 0..ROB_DEPTH directly.
  assign cnt   = tail_ptr - head_ptr;
  assign full  = (tail_idx == head_idx) && (tail_ptr[IDX_W] != head_wrap);
  assign empty = (tail_ptr == head_ptr);

  // Age of an index relative to the head (0 = oldest). An index is live when
  // its age is below the occupancy; this handles wrap without extra compares.
  function automatic logic [IDX_W:0] age_of(input logic [IDX_W-1:0] idx,
                                            input logic [IDX_W-1:0] hd);
    logic [IDX_W-1:0] diff;
    diff = idx - hd;
    return {1'b0, diff};
  endfunction

  logic [IDX_W:0] cmpl_age, sq_age;
  logic           cmpl_live, sq_live;

  assign cmpl_age  = age_of(rob_cmpl_idx_i, head_idx);
  assign sq_age    = age_of(rob_sq_idx_i, head_idx);
  assign cmpl_live = cmpl_age < cnt;
  assign sq_live   = rob_sq_vld_i && (sq_age < cnt);

  // ---------------------------------------------------------------------------
  // Request qualification. Flush outranks everything; a live squash drops the
  // same-cycle dispatch and any completion aimed at an entry it removes.
  // ---------------------------------------------------------------------------
  logic squash_go, dis_go, ret_go, cmpl_go;

  assign squash_go = !rob_flush_i && sq_live;
  assign dis_go    = rob_dis_vld_i && !full && !rob_flush_i && !sq_live;
  assign ret_go    = rob_ret_vld_o && rob_ret_rdy_i;
  assign cmpl_go   = rob_cmpl_vld_i && !rob_flush_i && cmpl_live &&
                     !(sq_live && (cmpl_age > sq_age));

  // The squash point's wrap bit: an index at or above the head index sits in
  // the head's lap, one below it has wrapped into the next lap.
  logic [IDX_W:0] sq_ptr;

  assign sq_ptr = {(rob_sq_idx_i >= head_idx) ? head_wrap : !head_wrap,
                   rob_sq_idx_i};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    head_nxt = head_ptr;
    tail_nxt = tail_ptr;
    done_nxt = done_q;

    if (rob_flush_i) begin
      head_nxt = '0;
      tail_nxt = '0;
      done_nxt = '0;
    end else begin
      if (ret_go) begin
        head_nxt = head_ptr + PTR_ONE;
      end

      if (squash_go) begin
        tail_nxt = sq_ptr + PTR_ONE;
      end else if (dis_go) begin
        tail_nxt = tail_ptr + PTR_ONE;
      end

      // Order matters: a retire clears the head even if it also completes
      // this cycle; a dispatch always starts its entry not-done.
      if (cmpl_go) begin
        done_nxt[rob_cmpl_idx_i] = 1'b1;
      end
      if (ret_go) begin
        done_nxt[head_idx] = 1'b0;
      end
      if (dis_go) begin
        done_nxt[tail_idx] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      done_q   <= '0;
      // NOTE: the entry storage is cleared on reset because the retire data
      // outputs expose entry[head] unconditionally and must read 0 after reset;
      // this costs a reset on every storage flop rather than a plain RAM.
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent_logic_dest[i] <= '0;
        ent_dest_tag[i]   <= '0;
        ent_old_tag[i]    <= '0;
      end
    end else begin
      head_ptr <= head_nxt;
      tail_ptr <= tail_nxt;
      done_q   <= done_nxt;
      if (dis_go) begin
        ent_logic_dest[tail_idx] <= rob_dis_logic_dest_i;
        ent_dest_tag[tail_idx]   <= rob_dis_dest_tag_i;
        ent_old_tag[tail_idx]    <= rob_dis_old_tag_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Ready is derived from the registered full flag only; a retire in the same
  // cycle does not open a slot until the next cycle.
  assign rob_dis_rdy_o = !full;
  assign rob_dis_idx_o = tail_idx;

  assign rob_ret_vld_o        = !empty && done_q[head_idx] && !rob_flush_i;
  assign rob_ret_logic_dest_o = ent_logic_dest[head_idx];
  assign rob_ret_dest_tag_o   = ent_dest_tag[head_idx];
  assign rob_ret_old_tag_o    = ent_old_tag[head_idx];

  assign rob_full_o  = full;
  assign rob_empty_o = empty;
  assign rob_cnt_o   = cnt;

endmodule

// File: tb/tb_rob_param.sv
// -----------------------------------------------------------------------------
// tb_rob_param -- self-checking bench for rob_param at ROB_DEPTH=8.
//
// The reference model tracks the ROB as a head position plus an occupancy
// count, with plain arrays for the done flags and entry fields. A negedge
// process compares every DUT output against the model each cycle and then
// advances the model from the inputs applied in that cycle. Directed
// sequences add literal expectations for the corner cases, followed by a
// randomized run.
// -----------------------------------------------------------------------------
module tb_rob_param;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int ARF_W = 5;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst;
  logic             rob_dis_vld_i;
  logic [ARF_W-1:0] rob_dis_logic_dest_i;
  logic [TAG_W-1:0] rob_dis_dest_tag_i;
  logic [TAG_W-1:0] rob_dis_old_tag_i;
  logic             rob_dis_rdy_o;
  logic [IDX_W-1:0] rob_dis_idx_o;
  logic             rob_cmpl_vld_i;
  logic [IDX_W-1:0] rob_cmpl_idx_i;
  logic             rob_ret_vld_o;
  logic             rob_ret_rdy_i;
  logic [ARF_W-1:0] rob_ret_logic_dest_o;
  logic [TAG_W-1:0] rob_ret_dest_tag_o;
  logic [TAG_W-1:0] rob_ret_old_tag_o;
  logic             rob_sq_vld_i;
  logic [IDX_W-1:0] rob_sq_idx_i;
  logic             rob_flush_i;
  logic             rob_full_o;
  logic             rob_empty_o;
  logic [IDX_W:0]   rob_cnt_o;

  rob_param #(
    .ROB_DEPTH(DEPTH),
    .TAG_W    (TAG_W),
    .ARF_W    (ARF_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rob_dis_vld_i       (rob_dis_vld_i),
    .rob_dis_logic_dest_i(rob_dis_logic_dest_i),
    .rob_dis_dest_tag_i  (rob_dis_dest_tag_i),
    .rob_dis_old_tag_i   (rob_dis_old_tag_i),
    .rob_dis_rdy_o       (rob_dis_rdy_o),
    .rob_dis_idx_o       (rob_dis_idx_o),
    .rob_cmpl_vld_i      (rob_cmpl_vld_i),
    .rob_cmpl_idx_i      (rob_cmpl_idx_i),
    .rob_ret_vld_o       (rob_ret_vld_o),
    .rob_ret_rdy_i       (rob_ret_rdy_i),
    .rob_ret_logic_dest_o(rob_ret_logic_dest_o),
    .rob_ret_dest_tag_o  (rob_ret_dest_tag_o),
    .rob_ret_old_tag_o   (rob_ret_old_tag_o),
    .rob_sq_vld_i        (rob_sq_vld_i),
    .rob_sq_idx_i        (rob_sq_idx_i),
    .rob_flush_i         (rob_flush_i),
    .rob_full_o          (rob_full_o),
    .rob_empty_o         (rob_empty_o),
    .rob_cnt_o           (rob_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: head position, occupancy, done flags, entry fields.
  // ---------------------------------------------------------------------------
  int m_head;
  int m_cnt;
  bit m_done [DEPTH];
  int m_ld   [DEPTH];
  int m_dt   [DEPTH];
  int m_ot   [DEPTH];

  function automatic int off(input int i);
    return (i - m_head + DEPTH) % DEPTH;
  endfunction

  bit e_ret_vld, do_ret, do_sq, do_dis, do_cmpl;
  int tl, ci, si;

  always @(negedge clk) begin
    if (rst) begin
      m_head = 0;
      m_cnt  = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_done[i] = 1'b0;
        m_ld[i] = 0;
        m_dt[i] = 0;
        m_ot[i] = 0;
      end
    end else begin
      tl        = (m_head + m_cnt) % DEPTH;
      e_ret_vld = (m_cnt != 0) && m_done[m_head] && !rob_flush_i;

      check("cnt",       32'(rob_cnt_o),            32'(m_cnt));
      check("full",      32'(rob_full_o),           32'(m_cnt == DEPTH));
      check("empty",     32'(rob_empty_o),          32'(m_cnt == 0));
      check("dis_rdy",   32'(rob_dis_rdy_o),        32'(m_cnt != DEPTH));
      check("dis_idx",   32'(rob_dis_idx_o),        32'(tl));
      check("ret_vld",   32'(rob_ret_vld_o),        32'(e_ret_vld));
      check("ret_ldest", 32'(rob_ret_logic_dest_o), 32'(m_ld[m_head]));
      check("ret_dtag",  32'(rob_ret_dest_tag_o),   32'(m_dt[m_head]));
      check("ret_otag",  32'(rob_ret_old_tag_o),    32'(m_ot[m_head]));

      if (rob_flush_i) begin
        m_head = 0;
        m_cnt  = 0;
        for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
      end else begin
        ci      = int'(rob_cmpl_idx_i);
        si      = int'(rob_sq_idx_i);
        do_ret  = e_ret_vld && rob_ret_rdy_i;
        do_sq   = rob_sq_vld_i && (off(si) < m_cnt);
        do_dis  = rob_dis_vld_i && (m_cnt < DEPTH) && !do_sq;
        do_cmpl = rob_cmpl_vld_i && (off(ci) < m_cnt) &&
                  !(do_sq && (off(ci) > off(si)));

        if (do_cmpl) m_done[ci] = 1'b1;
        if (do_ret)  m_done[m_head] = 1'b0;
        if (do_dis) begin
          m_done[tl] = 1'b0;
          m_ld[tl]   = int'(rob_dis_logic_dest_i);
          m_dt[tl]   = int'(rob_dis_dest_tag_i);
          m_ot[tl]   = int'(rob_dis_old_tag_i);
        end
        if (do_sq)  m_cnt = off(si) + 1;
        if (do_dis) m_cnt = m_cnt + 1;
        if (do_ret) begin
          m_cnt  = m_cnt - 1;
          m_head = (m_head + 1) % DEPTH;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle();
    rob_dis_vld_i        = 1'b0;
    rob_dis_logic_dest_i = '0;
    rob_dis_dest_tag_i   = '0;
    rob_dis_old_tag_i    = '0;
    rob_cmpl_vld_i       = 1'b0;
    rob_cmpl_idx_i       = '0;
    rob_ret_rdy_i        = 1'b0;
    rob_sq_vld_i         = 1'b0;
    rob_sq_idx_i         = '0;
    rob_flush_i          = 1'b0;
  endtask

  task automatic set_dis(input int k);
    rob_dis_vld_i        = 1'b1;
    rob_dis_logic_dest_i = ARF_W'(k);
    rob_dis_dest_tag_i   = TAG_W'(k + 7);
    rob_dis_old_tag_i    = TAG_W'(k + 13);
  endtask

  task automatic set_cmpl(input int idx);
    rob_cmpl_vld_i = 1'b1;
    rob_cmpl_idx_i = IDX_W'(idx);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_cycle();
    idle();
    rob_flush_i = 1'b1;
    nxt();
  endtask

  task automatic check_reset_state();
    check("rst_dis_rdy", 32'(rob_dis_rdy_o),        32'd1);
    check("rst_empty",   32'(rob_empty_o),          32'd1);
    check("rst_full",    32'(rob_full_o),           32'd0);
    check("rst_cnt",     32'(rob_cnt_o),            32'd0);
    check("rst_ret_vld", 32'(rob_ret_vld_o),        32'd0);
    check("rst_ldest",   32'(rob_ret_logic_dest_o), 32'd0);
    check("rst_dtag",    32'(rob_ret_dest_tag_o),   32'd0);
    check("rst_otag",    32'(rob_ret_old_tag_o),    32'd0);
    check("rst_dis_idx", 32'(rob_dis_idx_o),        32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    at_neg();
    check_reset_state();
    nxt();

    // Fill the ROB back-to-back; the ninth dispatch is refused.
    for (int k = 0; k < 8; k++) begin
      idle(); set_dis(k); nxt();
    end
    idle(); set_dis(8);
    at_neg();
    check("fill_full", 32'(rob_full_o),    32'd1);
    check("fill_rdy",  32'(rob_dis_rdy_o), 32'd0);
    check("fill_cnt",  32'(rob_cnt_o),     32'd8);
    nxt();
    idle();
    at_neg();
    check("fill_cnt_hold", 32'(rob_cnt_o),     32'd8);
    check("fill_tail",     32'(rob_dis_idx_o), 32'd0);
    nxt();
    flush_cycle();

    // Out-of-order completion, in-order retire.
    for (int k = 0; k < 3; k++) begin
      idle(); rob_ret_rdy_i = 1'b1; set_dis(20 + k); nxt();
    end
    idle(); rob_ret_rdy_i = 1'b1; set_cmpl(1);
    at_neg(); check("ooo_wait1", 32'(rob_ret_vld_o), 32'd0); nxt();
    idle(); rob_ret_rdy_i = 1'b1; set_cmpl(0);
    at_neg(); check("ooo_wait0", 32'(rob_ret_vld_o), 32'd0); nxt();
    idle(); rob_ret_rdy_i = 1'b1;
    at_neg();
    check("ooo_ret0_vld", 32'(rob_ret_vld_o),        32'd1);
    check("ooo_ret0_ld",  32'(rob_ret_logic_dest_o), 32'd20);
    nxt();
    idle(); rob_ret_rdy_i = 1'b1;
    at_neg();
    check("ooo_ret1_vld", 32'(rob_ret_vld_o),        32'd1);
    check("ooo_ret1_ld",  32'(rob_ret_logic_dest_o), 32'd21);
    nxt();
    idle(); rob_ret_rdy_i = 1'b1;
    at_neg();
    check("ooo_hold_vld", 32'(rob_ret_vld_o),        32'd0);
    check("ooo_hold_cnt", 32'(rob_cnt_o),            32'd1);
    check("ooo_hold_ld",  32'(rob_ret_logic_dest_o), 32'd22);
    nxt();

    // Move head to 6, then dispatch across the wrap and squash.
    flush_cycle();
    for (int k = 0; k < 6; k++) begin
      idle(); set_dis(30 + k); nxt();
    end
    for (int i = 0; i < 6; i++) begin
      idle(); rob_ret_rdy_i = 1'b1; set_cmpl(i); nxt();
    end
    repeat (2) begin
      idle(); rob_ret_rdy_i = 1'b1; nxt();
    end
    idle();
    at_neg();
    check("wrap_empty", 32'(rob_empty_o),   32'd1);
    check("wrap_tail",  32'(rob_dis_idx_o), 32'd6);
    nxt();
    for (int k = 0; k < 4; k++) begin
      idle(); set_dis(40 + k); nxt();
    end
    idle(); rob_sq_vld_i = 1'b1; rob_sq_idx_i = 3'd7; set_cmpl(0); set_dis(44);
    nxt();
    idle(); set_cmpl(0);
    at_neg();
    check("sq_tail", 32'(rob_dis_idx_o), 32'd0);
    check("sq_cnt",  32'(rob_cnt_o),     32'd2);
    nxt();

    // Full ROB with head done: retire proceeds, dispatch refused.
    idle(); set_cmpl(6); nxt();
    for (int k = 0; k < 6; k++) begin
      idle(); set_dis(50 + k); nxt();
    end
    idle(); set_dis(60); rob_ret_rdy_i = 1'b1;
    at_neg();
    check("fr_full",    32'(rob_full_o),    32'd1);
    check("fr_rdy",     32'(rob_dis_rdy_o), 32'd0);
    check("fr_ret_vld", 32'(rob_ret_vld_o), 32'd1);
    nxt();
    idle();
    at_neg();
    check("fr_cnt7", 32'(rob_cnt_o),     32'd7);
    check("fr_rdy1", 32'(rob_dis_rdy_o), 32'd1);
    check("fr_tail", 32'(rob_dis_idx_o), 32'd6);
    nxt();

    // Flush masks a ready retire and empties the ROB.
    flush_cycle();
    for (int k = 0; k < 5; k++) begin
      idle(); set_dis(70 + k); nxt();
    end
    idle(); set_cmpl(0); nxt();
    idle(); rob_flush_i = 1'b1; rob_ret_rdy_i = 1'b1; set_dis(80); set_cmpl(1);
    at_neg(); check("fl_ret_vld", 32'(rob_ret_vld_o), 32'd0); nxt();
    idle();
    at_neg();
    check("fl_empty",   32'(rob_empty_o),   32'd1);
    check("fl_cnt",     32'(rob_cnt_o),     32'd0);
    check("fl_dis_idx", 32'(rob_dis_idx_o), 32'd0);
    nxt();

    // Squash the head while it retires: ROB ends empty.
    for (int k = 0; k < 2; k++) begin
      idle(); set_dis(90 + k); nxt();
    end
    idle(); set_cmpl(0); nxt();
    idle(); rob_sq_vld_i = 1'b1; rob_sq_idx_i = 3'd0; rob_ret_rdy_i = 1'b1;
    at_neg(); check("sqh_ret_vld", 32'(rob_ret_vld_o), 32'd1); nxt();
    idle();
    at_neg();
    check("sqh_empty", 32'(rob_empty_o),   32'd1);
    check("sqh_cnt",   32'(rob_cnt_o),     32'd0);
    check("sqh_tail",  32'(rob_dis_idx_o), 32'd1);
    nxt();

    // Reset overrides flush, completion and dispatch while full.
    for (int k = 0; k < 8; k++) begin
      idle(); set_dis(100 + k); nxt();
    end
    idle(); rst = 1'b1; rob_flush_i = 1'b1; set_cmpl(3); set_dis(120);
    at_neg(); check("mr_full", 32'(rob_full_o), 32'd1); nxt();
    idle(); rst = 1'b0;
    at_neg(); check_reset_state(); nxt();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 9) < 6) set_dis(int'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) set_cmpl(int'($urandom_range(0, DEPTH - 1)));
      rob_ret_rdy_i = ($urandom_range(0, 9) < 7);
      rob_sq_vld_i  = ($urandom_range(0, 19) == 0);
      rob_sq_idx_i  = IDX_W'($urandom_range(0, DEPTH - 1));
      rob_flush_i   = ($urandom_range(0, 99) == 0);
      nxt();
    end
    idle();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 Parameter ROB_DEPTH, default 32, entry count; power of two, minimum 4.
REQ-002 Parameter TAG_W, default 6, physical register tag width.
REQ-003 Parameter ARF_W, default 5, logical register index width.
REQ-004 Derived IDX_W = clog2(ROB_DEPTH); head and tail pointers SHALL be IDX_W+1 bits, the MSB being the wrap bit.
REQ-005 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rob_dis_vld_i  in  1  dispatch request.
REQ-008 rob_dis_logic_dest_i  in  ARF_W  logical destination.
REQ-009 rob_dis_dest_tag_i  in  TAG_W  new physical tag from freelist.
REQ-010 rob_dis_old_tag_i  in  TAG_W  previous mapping from maptable.
REQ-011 rob_dis_rdy_o  out  1  entry available; SHALL equal ~rob_full_o.
REQ-012 rob_dis_idx_o  out  IDX_W  index the current dispatch is written to (tail index).
REQ-013 rob_cmpl_vld_i / rob_cmpl_idx_i  in  1 / IDX_W  execution-complete strobe and ROB index.
REQ-014 rob_ret_vld_o  out  1  head entry ready to retire.
REQ-015 rob_ret_rdy_i  in  1  retire consumer (freelist/arch map) accepts.
REQ-016 rob_ret_logic_dest_o / rob_ret_dest_tag_o / rob_ret_old_tag_o  out  ARF_W / TAG_W / TAG_W  head entry fields.
REQ-017 rob_sq_vld_i / rob_sq_idx_i  in  1 / IDX_W  branch mispredict; entries younger than rob_sq_idx_i are squashed.
REQ-018 rob_flush_i  in  1  full flush (exception).
REQ-019 rob_full_o, rob_empty_o  out  1 each; rob_cnt_o  out  IDX_W+1  occupancy.

Function
REQ-020 Occupancy SHALL be tail-head modulo 2^(IDX_W+1); full when index bits equal and wrap bits differ; empty when pointers equal.
REQ-021 Index i SHALL be live when (i - head_idx) mod ROB_DEPTH < rob_cnt_o.
REQ-022 Dispatch fires when rob_dis_vld_i & rob_dis_rdy_o: entry[tail] gets the three fields, done[tail] cleared, tail increments with wrap next cycle.
REQ-023 rob_dis_rdy_o SHALL use registered full only; no bypass from a same-cycle retire.
REQ-024 Completion SHALL set done[rob_cmpl_idx_i] next cycle only if that index is live; a non-live index SHALL be ignored.
REQ-025 rob_ret_vld_o SHALL be combinational: ~empty & done[head] & ~rob_flush_i; retire data outputs SHALL always present entry[head].
REQ-026 Retire fires when rob_ret_vld_o & rob_ret_rdy_i: head increments, done[head] cleared; at most one retire per cycle.
REQ-027 Retire and dispatch in the same cycle SHALL both proceed; occupancy unchanged.
REQ-028 Squash with live rob_sq_idx_i: tail SHALL become sq_ptr+1, where sq_ptr wrap bit = head wrap if rob_sq_idx_i >= head_idx, else inverted head wrap.
REQ-029 Squash with non-live rob_sq_idx_i SHALL be ignored.
REQ-030 In a squash cycle, dispatch SHALL be dropped; a retire SHALL still proceed; completions to squashed indices SHALL be ignored.
REQ-031 Squash of the head entry coinciding with its retire SHALL leave the ROB empty.
REQ-032 rob_flush_i SHALL have highest priority: next cycle head=tail=0 and all done bits cleared; dispatch, completion, squash and retire SHALL be ignored that cycle.
REQ-033 Pointers SHALL wrap from ROB_DEPTH-1 to 0, toggling the wrap bit.

Reset
REQ-034 During rst, head=tail=0, all done bits and entry fields 0.
REQ-035 After reset: rob_dis_rdy_o=1, rob_empty_o=1, rob_full_o=0, rob_cnt_o=0, rob_ret_vld_o=0, retire data 0, rob_dis_idx_o=0.
REQ-036 rst asserted mid-operation SHALL override all inputs, including rob_flush_i.

Verification (ROB_DEPTH=8)
REQ-037 Dispatch 8 entries back-to-back -> rob_full_o=1, rob_dis_rdy_o=0, rob_cnt_o=8; 9th dispatch dropped, tail unchanged.
REQ-038 Dispatch idx0-2, complete idx1 then idx0 -> rob_ret_vld_o rises only after idx0 done; idx0 and idx1 retire on consecutive cycles with rob_ret_rdy_i=1; idx2 held.
REQ-039 Head=6, dispatch 4 (indices 6,7,0,1), squash idx 7 -> tail index 0 with head wrap, rob_cnt_o=2; completion to idx 0 ignored.
REQ-040 Full ROB with head done, retire and dispatch same cycle -> dispatch refused (rdy_o=0); next cycle rob_cnt_o=7, rdy_o=1.
REQ-041 rob_flush_i with 5 live entries and head done, rob_ret_rdy_i=1 -> rob_ret_vld_o=0 that cycle; next cycle empty, cnt 0, dis_idx 0.
REQ-042 rst asserted while full with pending completion -> next cycle all REQ-035 values.
